// File: rtl/i2s_serializer.sv
// I2S master transmitter: divides sclk down to bclk and serializes buffered
// left/right sample pairs MSB first. Data lags lrclk by one bit. When no
// sample is buffered at the load point, the frame carries zeros and underrun
// pulses for one cycle.
module i2s_serializer #(
    parameter int WIDTH = 16
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic [15:0]      prescaler,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun
);

    localparam int FW = 2 * WIDTH;
    localparam int CW = $clog2(FW);
    localparam logic [CW-1:0] LAST_SLOT   = CW'(FW - 1);
    localparam logic [CW-1:0] FIRST_RIGHT = CW'(WIDTH);
    localparam logic [CW-1:0] LOAD_SLOT   = CW'(1);
    localparam logic [CW-1:0] FRAME_SLOT  = '0;

    logic [15:0]     r_presc_q;
    logic [15:0]     r_div;
    logic            r_bclk;
    logic            r_lrclk;
    logic [CW-1:0]   r_bit_cnt;
    logic [FW-1:0]   r_sh;
    logic [FW-1:0]   r_buf;
    logic            r_full;
    logic            r_underrun;

    logic [15:0]     w_half;
    logic            w_tick;
    logic            w_fall;
    logic [CW-1:0]   w_next_slot;
    logic            w_accept;
    logic            w_load;

    // A prescaler of zero would stall the divider, so it runs as one.
    assign w_half      = (r_presc_q == 16'd0) ? 16'd1 : r_presc_q;
    assign w_tick      = (r_div == w_half - 16'd1);
    assign w_fall      = w_tick && r_bclk;
    assign w_next_slot = (r_bit_cnt == LAST_SLOT) ? FRAME_SLOT : r_bit_cnt + CW'(1);
    assign w_accept    = sample_valid && !r_full;
    assign w_load      = w_fall && (w_next_slot == LOAD_SLOT);

    assign sample_ready = !r_full;
    assign bclk         = r_bclk;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sh[FW-1];
    assign underrun     = r_underrun;

    // Half-period divider toggling bclk; the divide ratio is only re-read at a frame boundary.
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_div     <= 16'd0;
            r_bclk    <= 1'b0;
            r_presc_q <= prescaler;
        end else if (w_tick) begin
            r_div  <= 16'd0;
            r_bclk <= ~r_bclk;
            if (w_fall && (w_next_slot == FRAME_SLOT)) begin
                r_presc_q <= prescaler;
            end
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    // On each bclk falling toggle advance the slot, update lrclk and load or shift the frame word.
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_bit_cnt  <= LAST_SLOT;
            r_lrclk    <= 1'b0;
            r_sh       <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_fall) begin
                r_bit_cnt <= w_next_slot;
                r_lrclk   <= (w_next_slot >= FIRST_RIGHT);
                if (w_next_slot == LOAD_SLOT) begin
                    if (r_full) begin
                        r_sh <= r_buf;
                    end else begin
                        r_sh       <= '0;
                        r_underrun <= 1'b1;
                    end
                end else begin
                    r_sh <= r_sh << 1;
                end
            end
        end
    end

    // Holding-buffer occupancy: set on handshake, cleared when the frame load consumes it.
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_full <= 1'b1;
        end else if (w_load) begin
            r_full <= 1'b0;
        end
    end

    // Holding-buffer data; only meaningful while r_full is set, so it needs no reset.
    always_ff @(posedge sclk) begin
        if (w_accept) begin
            r_buf <= {left_in, right_in};
        end
    end

endmodule

// File: tb/tb_i2s_serializer.sv
// Bench for i2s_serializer: a frame-level reference model (time offsets within
// each frame, a one-entry sample buffer) checked against the DUT every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_i2s_serializer;

    localparam int W = 16;

    logic           sclk = 1'b0;
    logic           rst = 1'b1;
    logic [15:0]    prescaler = 16'd2;
    logic [W-1:0]   left_in = '0;
    logic [W-1:0]   right_in = '0;
    logic           sample_valid = 1'b0;
    logic           sample_ready;
    logic           bclk;
    logic           lrclk;
    logic           sdata;
    logic           underrun;

    int vec = 0;
    int miscmp = 0;

    i2s_serializer #(.WIDTH(W)) dut (
        .sclk(sclk),
        .rst(rst),
        .prescaler(prescaler),
        .left_in(left_in),
        .right_in(right_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .bclk(bclk),
        .lrclk(lrclk),
        .sdata(sdata),
        .underrun(underrun)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pmax(input logic [15:0] p);
        return (p == 16'd0) ? 1 : int'(p);
    endfunction

    // ---------------- reference model ----------------
    // After reset release there is a lead-in of 2*P0 cycles (bclk low then high),
    // then frames of 4*W*Pf cycles each, offset k counted from slot-0 entry.
    bit            m_on = 0;
    bit            m_pre;
    int            m_e, m_k, m_p0, m_pf;
    bit            m_full, m_und, m_old;
    logic [W-1:0]  m_bl, m_br;
    logic [2*W-1:0] m_word;
    logic          s_rst, s_v;
    logic [15:0]   s_p;
    logic [W-1:0]  s_l, s_r;
    int            m_half, m_slot;
    logic          eb, el, ed;

    always @(posedge sclk) begin
        s_rst = rst; s_p = prescaler; s_v = sample_valid; s_l = left_in; s_r = right_in;
        if (s_rst) begin
            m_on = 1; m_pre = 1; m_e = 0; m_k = 0; m_p0 = pmax(s_p); m_pf = m_p0;
            m_full = 0; m_und = 0; m_word = '0;
        end else if (m_on) begin
            m_old = m_full;
            m_und = 0;
            if (m_pre) begin
                m_e++;
                if (m_e == 2 * m_p0) begin
                    m_pre = 0; m_k = 0; m_pf = pmax(s_p);
                end
            end else begin
                m_k++;
                if (m_k == 4 * W * m_pf) begin
                    m_k = 0; m_pf = pmax(s_p);
                end
                if (m_k == 2 * m_pf) begin
                    if (m_full) begin
                        m_word = {m_bl, m_br}; m_full = 0;
                    end else begin
                        m_word = '0; m_und = 1;
                    end
                end
            end
            if (s_v && !m_old) begin
                m_bl = s_l; m_br = s_r; m_full = 1;
            end
        end
        #1;
        if (m_on) begin
            if (m_pre) begin
                eb = (m_e >= m_p0); el = 1'b0; ed = 1'b0;
            end else begin
                m_half = m_k / m_pf;
                m_slot = m_half / 2;
                eb = (m_half % 2) == 1;
                el = (m_slot >= W);
                ed = (m_slot == 0) ? m_word[0] : m_word[2*W - m_slot];
            end
            chk("cycle {bclk,lrclk,sdata,ready,underrun}",
                32'({bclk, lrclk, sdata, sample_ready, underrun}),
                32'({eb, el, ed, ~m_full, m_und}));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset(input logic [15:0] p, input logic push,
                            input logic [W-1:0] l, input logic [W-1:0] r);
        @(negedge sclk);
        rst = 1'b1; sample_valid = 1'b0; prescaler = p;
        repeat (3) @(negedge sclk);
        chk("reset_outputs", 32'({bclk, lrclk, sdata, sample_ready, underrun}), 32'h2);
        rst = 1'b0; sample_valid = push; left_in = l; right_in = r;
    endtask

    task automatic next_rise(output int c);
        logic prev;
        c = 0;
        prev = bclk;
        do begin
            @(negedge sclk);
            c++;
            if (!prev && bclk) return;
            prev = bclk;
        end while (c < 200);
        chk("bclk_rise_timeout", 32'(c), 32'd0);
    endtask

    task automatic wait_rises(input int n);
        int c;
        for (int i = 0; i < n; i++) next_rise(c);
    endtask

    task automatic wait_und(output int c);
        c = 0;
        do begin
            @(negedge sclk);
            c++;
        end while (!underrun && c < 1000);
        if (!underrun) chk("underrun_timeout", 32'(c), 32'd0);
    endtask

    // Collect lrclk at rises 2..33 (slots 0..31) and sdata at rises 3..34
    // (slots 1..31 plus next slot 0); count underrun pulses meanwhile.
    task automatic capture(output logic [31:0] sd, output logic [31:0] lr,
                           output int und, output int first_rise);
        int n, cyc;
        logic prev;
        n = 0; cyc = 0; sd = '0; lr = '0; und = 0; first_rise = -1;
        prev = bclk;
        while (n < 34 && cyc < 2000) begin
            @(negedge sclk);
            cyc++;
            sample_valid = 1'b0;
            if (underrun) und++;
            if (!prev && bclk) begin
                n++;
                if (n == 1) first_rise = cyc;
                if (n >= 2 && n <= 33) lr = {lr[30:0], lrclk};
                if (n >= 3) sd = {sd[30:0], sdata};
            end
            prev = bclk;
        end
        if (n < 34) chk("capture_timeout", 32'(n), 32'd34);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] sd, lr;
        int und, fr, c;

        // Single loaded frame, P=2.
        do_reset(16'd2, 1'b1, 16'hA5C3, 16'h0F0F);
        capture(sd, lr, und, fr);
        chk("first_rise_P2", 32'(fr), 32'd2);
        chk("frame_sdata", sd, 32'hA5C30F0F);
        chk("frame_lrclk", lr, 32'h0000FFFF);
        chk("frame_no_underrun", 32'(und), 32'd0);

        // Starved frames: underrun once per 128-cycle frame.
        wait_und(c);
        wait_und(c);
        chk("underrun_gap_P2", 32'(c), 32'd128);

        // Mid-frame reset with a full buffer; the buffered sample is discarded.
        do_reset(16'd2, 1'b1, 16'h1111, 16'h2222);
        wait_rises(3);
        sample_valid = 1'b1; left_in = 16'h1234; right_in = 16'h5678;
        @(negedge sclk);
        sample_valid = 1'b0;
        chk("buffer_full_ready_low", 32'(sample_ready), 32'd0);
        wait_rises(19);
        rst = 1'b1;
        @(negedge sclk);
        chk("midframe_reset_outputs", 32'({bclk, lrclk, sdata, sample_ready, underrun}), 32'h2);
        rst = 1'b0;
        capture(sd, lr, und, fr);
        chk("after_reset_sdata_zero", sd, 32'h0);
        chk("after_reset_lrclk", lr, 32'h0000FFFF);
        chk("after_reset_one_underrun", 32'(und), 32'd1);

        // Prescaler 0 behaves as 1: bclk period 2.
        do_reset(16'd0, 1'b0, '0, '0);
        next_rise(c);
        chk("first_rise_P0", 32'(c), 32'd1);
        next_rise(c);
        chk("bclk_period_P0", 32'(c), 32'd2);

        // Mid-frame change 2 -> 4 takes effect at the next frame.
        do_reset(16'd2, 1'b0, '0, '0);
        wait_rises(10);
        prescaler = 16'd4;
        next_rise(c);
        chk("period_same_frame", 32'(c), 32'd4);
        wait_rises(29);
        next_rise(c);
        chk("period_next_frame", 32'(c), 32'd8);

        // Randomized traffic checked by the model every cycle.
        do_reset(16'($urandom_range(0, 3)), 1'b0, '0, '0);
        for (int i = 0; i < 12000; i++) begin
            @(negedge sclk);
            rst = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 399) == 0) prescaler = 16'($urandom_range(0, 3));
            sample_valid = (i < 6000) ? ($urandom_range(0, 3) != 0)
                                      : ($urandom_range(0, 199) == 0);
            left_in  = W'($urandom);
            right_in = W'($urandom);
        end
        @(negedge sclk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
